// File: rtl/ring_resp.sv
// Responder end of the ring protocol: returns an ack token around a K-hop ring,
// retransmitting after a timeout when the token is lost, up to a retry budget.
module ring_resp #(
    parameter int unsigned K        = 8,
    parameter int unsigned TIMEOUT  = 3,
    parameter int unsigned MAX_RETX = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       loss,
    input  logic       controllable_ack,
    output logic       ack_valid,
    output logic [5:0] hop,
    output logic [2:0] retx_cnt,
    output logic       error,
    output logic       objective
);

    localparam int unsigned HOP_W  = 6;
    localparam int unsigned TMO_W  = 4;
    localparam int unsigned RETX_W = 3;

    localparam logic [HOP_W-1:0]  HOP_PENULT = HOP_W'(K - 2);
    localparam logic [HOP_W-1:0]  HOP_LAST   = HOP_W'(K - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(TIMEOUT - 1);
    localparam logic [RETX_W-1:0] RETX_MAX   = RETX_W'(MAX_RETX);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_SEND  = 3'd2,
        ST_LOST  = 3'd3,
        ST_DONE  = 3'd4,
        ST_FAIL  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [HOP_W-1:0]    hop_q, hop_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [RETX_W-1:0]   retx_q, retx_d;

    // State and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            hop_q   <= '0;
            tmo_q   <= '0;
            retx_q  <= '0;
        end else begin
            state_q <= state_d;
            hop_q   <= hop_d;
            tmo_q   <= tmo_d;
            retx_q  <= retx_d;
        end
    end

    // Next-state and counter update
    always_comb begin
        state_d = state_q;
        hop_d   = hop_q;
        tmo_d   = tmo_q;
        retx_d  = retx_q;
        case (state_q)
            ST_IDLE: begin
                // An ack with no pending request is a violation, even alongside req
                if (controllable_ack) begin
                    state_d = ST_FAIL;
                end else if (req) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (controllable_ack) begin
                    state_d = ST_SEND;
                    hop_d   = '0;
                    tmo_d   = '0;
                end
            end
            ST_SEND: begin
                if (loss) begin
                    state_d = ST_LOST;
                    tmo_d   = '0;
                end else if (hop_q == HOP_PENULT) begin
                    state_d = ST_DONE;
                    hop_d   = HOP_LAST;
                end else begin
                    hop_d = hop_q + HOP_W'(1);
                end
            end
            ST_LOST: begin
                if (tmo_q == TMO_LAST) begin
                    if (retx_q == RETX_MAX) begin
                        state_d = ST_FAIL;
                    end else begin
                        state_d = ST_SEND;
                        retx_d  = retx_q + RETX_W'(1);
                        hop_d   = '0;
                        tmo_d   = '0;
                    end
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_DONE: begin
                if (req) begin
                    state_d = ST_ARMED;
                    retx_d  = '0;
                    hop_d   = '0;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode registered state only
    assign ack_valid = (state_q == ST_SEND);
    assign objective = (state_q == ST_DONE);
    assign error     = (state_q == ST_FAIL);
    assign hop       = hop_q;
    assign retx_cnt  = retx_q;

endmodule

// File: tb/tb_ring_resp.sv
// Directed self-checking bench for ring_resp (K=8, TIMEOUT=3, MAX_RETX=2).
module tb_ring_resp;

    logic       clk;
    logic       reset;
    logic       req;
    logic       loss;
    logic       controllable_ack;
    logic       ack_valid;
    logic [5:0] hop;
    logic [2:0] retx_cnt;
    logic       error;
    logic       objective;

    int n_chk;
    int n_pass;

    ring_resp #(.K(8), .TIMEOUT(3), .MAX_RETX(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .req              (req),
        .loss             (loss),
        .controllable_ack (controllable_ack),
        .ack_valid        (ack_valid),
        .hop              (hop),
        .retx_cnt         (retx_cnt),
        .error            (error),
        .objective        (objective)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int av, input int hp, input int rc,
                           input int er, input int ob);
        chk({tag, ".ack_valid"}, int'(ack_valid), av);
        chk({tag, ".hop"},       int'(hop),       hp);
        chk({tag, ".retx_cnt"},  int'(retx_cnt),  rc);
        chk({tag, ".error"},     int'(error),     er);
        chk({tag, ".objective"}, int'(objective), ob);
    endtask

    // Advance one clock edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Mid-cycle async reset pulse, checked before the next edge
    task automatic reset_pulse(input string tag);
        #2;
        reset = 1'b1;
        #1;
        chk_out({tag, ".during"}, 0, 0, 0, 0, 0);
        #2;
        reset = 1'b0;
        req = 1'b0;
        loss = 1'b0;
        controllable_ack = 1'b0;
        step();
        chk_out({tag, ".after"}, 0, 0, 0, 0, 0);
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        reset = 1'b1;
        req = 1'b0;
        loss = 1'b0;
        controllable_ack = 1'b0;

        #3;
        chk_out("rst_hold", 0, 0, 0, 0, 0);
        step();
        step();
        #3;
        reset = 1'b0;
        step();
        chk_out("rst_release", 0, 0, 0, 0, 0);

        // Clean delivery
        req = 1'b1;
        step();
        req = 1'b0;
        chk_out("clean.armed", 0, 0, 0, 0, 0);
        controllable_ack = 1'b1;
        step();
        controllable_ack = 1'b0;
        for (int i = 0; i < 7; i++) begin
            chk_out($sformatf("clean.send%0d", i), 1, i, 0, 0, 0);
            step();
        end
        chk_out("clean.done", 0, 7, 0, 0, 1);
        step();
        chk_out("clean.done_hold", 0, 7, 0, 0, 1);

        // Re-arm from DONE, then single loss at hop 3 with req held high throughout
        req = 1'b1;
        step();
        chk_out("rearm1.armed", 0, 0, 0, 0, 0);
        controllable_ack = 1'b1;
        step();
        controllable_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_out($sformatf("loss.send%0d", i), 1, i, 0, 0, 0);
            step();
        end
        chk_out("loss.send3", 1, 3, 0, 0, 0);
        loss = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            chk_out($sformatf("loss.lost%0d", i), 0, 3, 0, 0, 0);
            step();
            loss = 1'b0;
        end
        for (int i = 0; i < 7; i++) begin
            chk_out($sformatf("loss.resend%0d", i), 1, i, 1, 0, 0);
            step();
        end
        chk_out("loss.done", 0, 7, 1, 0, 1);
        step();
        chk_out("rearm2.armed", 0, 0, 0, 0, 0);
        req = 1'b0;

        // Budget exhaustion: lose the token on the first hop of every attempt
        controllable_ack = 1'b1;
        step();
        controllable_ack = 1'b0;
        for (int a = 0; a < 3; a++) begin
            chk_out($sformatf("budget.send%0d", a), 1, 0, a, 0, 0);
            loss = 1'b1;
            step();
            loss = 1'b0;
            chk_out($sformatf("budget.lost%0d", a), 0, 0, a, 0, 0);
            step();
            step();
            step();
        end
        chk_out("budget.fail", 0, 0, 2, 1, 0);
        for (int i = 0; i < 22; i++) begin
            req = 1'(i % 2);
            loss = 1'(i % 3 == 0);
            controllable_ack = 1'(i % 4 == 1);
            step();
            chk($sformatf("budget.sticky%0d", i), int'(error), 1);
        end
        chk_out("budget.frozen", 0, 0, 2, 1, 0);

        // Reset clears FAIL; then reset mid-SEND at hop 4
        reset_pulse("rst_fail");
        req = 1'b1;
        step();
        req = 1'b0;
        controllable_ack = 1'b1;
        step();
        controllable_ack = 1'b0;
        repeat (4) step();
        chk_out("midsend.hop4", 1, 4, 0, 0, 0);
        reset_pulse("rst_send");
        req = 1'b1;
        step();
        req = 1'b0;
        chk_out("restart.armed", 0, 0, 0, 0, 0);
        controllable_ack = 1'b1;
        step();
        controllable_ack = 1'b0;
        chk_out("restart.send0", 1, 0, 0, 0, 0);

        // Spurious ack in IDLE without req
        reset_pulse("rst_sp1");
        controllable_ack = 1'b1;
        step();
        controllable_ack = 1'b0;
        chk_out("spur.noreq", 0, 0, 0, 1, 0);
        for (int i = 0; i < 21; i++) begin
            req = 1'(i % 2);
            step();
        end
        req = 1'b0;
        chk_out("spur.hold", 0, 0, 0, 1, 0);

        // Spurious ack with simultaneous req: violation wins
        reset_pulse("rst_sp2");
        req = 1'b1;
        controllable_ack = 1'b1;
        step();
        req = 1'b0;
        controllable_ack = 1'b0;
        chk_out("spur.withreq", 0, 0, 0, 1, 0);
        repeat (20) step();
        chk_out("spur.withreq_hold", 0, 0, 0, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
